conseq00_stream_sched: RTL and testbench

//  Shares one even_odd_conseq00 serial detector between NREQ requesters.

---
 rtl/conseq00_stream_sched_pkg.sv | 23 ++
 rtl/conseq00_stream_sched_if.sv | 29 ++
 rtl/conseq00_stream_sched_rr_arbiter.sv | 30 +++
 rtl/conseq00_stream_sched.sv | 133 +++++++++++++
 tb/tb_conseq00_stream_sched.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conseq00_stream_sched_pkg.sv
// Shared types and helpers for the conseq00 stream scheduler.
package conseq00_stream_sched_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Ceiling log2, used to size requester IDs, bit counters and hit counts
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int p = 1; p < value; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/conseq00_stream_sched_if.sv
// Requester / result bundle between the parallel producers and the scheduler.
interface conseq00_stream_sched_if
    import conseq00_stream_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W  = clog2(NREQ);
    localparam int HIT_W = clog2(WIDTH + 1);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [WIDTH-1:0]      res_flags;
    logic [HIT_W-1:0]      res_hits;

    modport master (
        output req, req_data,
        input  gnt, res_valid, res_id, res_flags, res_hits
    );

    modport slave (
        input  req, req_data,
        output gnt, res_valid, res_id, res_flags, res_hits
    );

endinterface

// File: rtl/conseq00_stream_sched_rr_arbiter.sv
// Round-robin pick: first set request searching upward from ptr, wrapping.
module conseq00_stream_sched_rr_arbiter
    import conseq00_stream_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]        grant
);
    localparam int ID_W = clog2(NREQ);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk the requesters in priority order starting at ptr; first hit wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ID_W'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conseq00_stream_sched.sv
// Shares one external serial detector between NREQ requesters: arbitrates,
// clears the detector, shifts the winning word in MSB-first and collects
// the detector output after every bit into a flag vector and hit count.
//
// state | meaning
// IDLE  | waiting for a request; grant is issued combinationally here
// CLEAR | detector held in reset for one cycle
// SHIFT | word bits on det_x, MSB first; flags captured from 2nd bit on
// DRAIN | det_x low; capture flag for the last bit, load result registers
// DONE  | res_valid pulse; back to IDLE next cycle
module conseq00_stream_sched
    import conseq00_stream_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    conseq00_stream_sched_if.slave  bus,
    output logic                    det_rst_n,
    output logic                    det_x,
    input  logic                    det_y
);
    localparam int ID_W  = clog2(NREQ);
    localparam int HIT_W = clog2(WIDTH + 1);
    localparam int CNT_W = clog2(WIDTH);

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  win_id;
    logic [NREQ-1:0]  arb_gnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] flags_nxt;
    logic [HIT_W-1:0] hits_nxt;
    logic [CNT_W-1:0] cnt;

    conseq00_stream_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (arb_gnt)
    );

    // A grant is only meaningful while idle; it doubles as the sample strobe
    assign bus.gnt = (state == ST_IDLE) ? arb_gnt : '0;
    assign det_x   = (state == ST_SHIFT) & shreg[WIDTH-1];

    // Encode the one-hot winner and select its word
    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                win_id   = ID_W'(k);
                win_data = bus.req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Oldest captured flag ends up at the MSB; popcount of the final vector
    always_comb begin
        flags_nxt = {flags[WIDTH-2:0], det_y};
        hits_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hits_nxt = hits_nxt + HIT_W'(flags_nxt[i]);
        end
    end

    // Sequencing FSM with registered detector reset and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            id_q          <= '0;
            shreg         <= '0;
            flags         <= '0;
            cnt           <= '0;
            det_rst_n     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_flags <= '0;
            bus.res_hits  <= '0;
        end else begin
            det_rst_n     <= 1'b1;
            bus.res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        shreg     <= win_data;
                        id_q      <= win_id;
                        ptr       <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
                        flags     <= '0;
                        det_rst_n <= 1'b0;
                        state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    // det_y during the first bit still shows the cleared state
                    if (cnt != CNT_W'(WIDTH - 1)) begin
                        flags <= flags_nxt;
                    end
                    if (cnt == '0) begin
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    flags         <= flags_nxt;
                    bus.res_valid <= 1'b1;
                    bus.res_id    <= id_q;
                    bus.res_flags <= flags_nxt;
                    bus.res_hits  <= hits_nxt;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conseq00_stream_sched.sv
// Bench for conseq00_stream_sched: behavioural detector on det_*, a cycle
// reference model of arbitration/shifting/results, directed and random stimulus.
module tb_conseq00_stream_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic det_rst_n, det_x, det_y;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    conseq00_stream_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    conseq00_stream_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .det_rst_n (det_rst_n),
        .det_x     (det_x),
        .det_y     (det_y)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Detector stand-in: y=1 when an odd number of 0s and an even number of 1s were seen
    logic z_odd, o_odd;
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            z_odd <= 1'b0;
            o_odd <= 1'b0;
        end else if (det_x) begin
            o_odd <= ~o_odd;
        end else begin
            z_odd <= ~z_odd;
        end
    end
    assign det_y = z_odd & ~o_odd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected flags from prefix counts of the word, MSB first
    function automatic logic [7:0] ref_flags(input logic [7:0] d);
        int z, o;
        logic [7:0] r;
        z = 0; o = 0; r = '0;
        for (int k = 0; k < 8; k++) begin
            if (d[7-k]) o++; else z++;
            r[7-k] = ((z % 2) == 1) && ((o % 2) == 0);
        end
        return r;
    endfunction

    function automatic logic [3:0] rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return 4'(1 << ((p + i) % NREQ));
        end
        return 4'b0;
    endfunction

    // Reference model state
    bit         active = 0;
    bit         armed = 0;
    int         rr_ptr = 0;
    int         g_cyc = 0;
    int         g_id = 0;
    logic [7:0] g_data = '0;
    int         held_id = 0;
    logic [7:0] held_flags = '0;
    int         held_hits = 0;
    logic [3:0] granted_mask = '0;
    int         dut_res_cnt = 0;
    int         dut_gnt_ids[$];
    int         dut_gnt_cyc[$];
    int         dut_res_ids[$];

    // Monitor: compare every DUT output against the model each cycle
    initial forever begin
        logic [3:0] exp_g;
        logic       exp_x;
        logic       exp_v;
        int         widx;
        @(negedge clk);
        if (!reset_n) begin
            chk("rst_gnt", 32'(bus.gnt), 0);
            chk("rst_det_rst_n", 32'(det_rst_n), 0);
            chk("rst_det_x", 32'(det_x), 0);
            chk("rst_res_valid", 32'(bus.res_valid), 0);
            chk("rst_res_id", 32'(bus.res_id), 0);
            chk("rst_res_flags", 32'(bus.res_flags), 0);
            chk("rst_res_hits", 32'(bus.res_hits), 0);
            active = 0; armed = 0; rr_ptr = 0;
            held_id = 0; held_flags = '0; held_hits = 0;
        end else begin
            exp_g = active ? 4'b0 : rr_pick(bus.req, rr_ptr);
            chk("gnt", 32'(bus.gnt), 32'(exp_g));
            chk("det_rst_n", 32'(det_rst_n), 32'(armed && !(active && cyc == g_cyc + 1)));
            armed = 1;
            exp_x = 1'b0;
            if (active && cyc >= g_cyc + 2 && cyc <= g_cyc + 9) exp_x = g_data[9 + g_cyc - cyc];
            chk("det_x", 32'(det_x), 32'(exp_x));
            exp_v = active && (cyc == g_cyc + 11);
            chk("res_valid", 32'(bus.res_valid), 32'(exp_v));
            if (exp_v) begin
                held_id    = g_id;
                held_flags = ref_flags(g_data);
                held_hits  = $countones(held_flags);
                active     = 0;
            end
            chk("res_id", 32'(bus.res_id), 32'(held_id));
            chk("res_flags", 32'(bus.res_flags), 32'(held_flags));
            chk("res_hits", 32'(bus.res_hits), 32'(held_hits));
            if (exp_g != 0) begin
                widx = 0;
                for (int k = 0; k < NREQ; k++) if (exp_g[k]) widx = k;
                active = 1; g_cyc = cyc; g_id = widx;
                g_data = bus.req_data[widx*WIDTH +: WIDTH];
                rr_ptr = (widx + 1) % NREQ;
                granted_mask = granted_mask | exp_g;
            end
            if (bus.gnt != 0) begin
                widx = 0;
                for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) widx = k;
                dut_gnt_ids.push_back(widx);
                dut_gnt_cyc.push_back(cyc);
            end
            if (bus.res_valid) begin
                dut_res_cnt++;
                dut_res_ids.push_back(int'(bus.res_id));
            end
        end
    end

    task automatic wait_any_gnt(output logic [3:0] g, output int c);
        bit ok;
        ok = 0; g = '0; c = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.gnt != 0) begin
                g = bus.gnt; c = cyc; ok = 1;
                break;
            end
        end
        chk("gnt_timeout", 32'(ok), 1);
    endtask

    task automatic wait_res();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1;
                break;
            end
        end
        chk("res_timeout", 32'(ok), 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send_one(input int k, input logic [7:0] d, output logic [3:0] g, output int c);
        @(posedge clk); #1;
        bus.req_data[k*WIDTH +: WIDTH] = d;
        bus.req[k] = 1'b1;
        wait_any_gnt(g, c);
        @(posedge clk); #1;
        bus.req[k] = 1'b0;
    endtask

    initial begin
        logic [3:0] g, g2;
        int         c, c2, seen, rb;
        bus.req = '0;
        bus.req_data = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset release, idle
        @(posedge clk);
        @(negedge clk);
        chk("drst_after_release", 32'(det_rst_n), 1);
        rb = dut_gnt_ids.size();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt != 0 || bus.res_valid || det_x) seen++;
        end
        chk("idle_quiet", 32'(seen), 0);
        chk("idle_no_gnt", 32'(dut_gnt_ids.size() - rb), 0);

        // Single word 8'hFF on req0
        send_one(0, 8'hFF, g, c);
        chk("ff_gnt", 32'(g), 32'b0001);
        wait_res();
        chk("ff_latency", 32'(cyc - c), 11);
        chk("ff_id", 32'(bus.res_id), 0);
        chk("ff_flags", 32'(bus.res_flags), 0);
        chk("ff_hits", 32'(bus.res_hits), 0);

        // 8'b1110_1000 on req0
        send_one(0, 8'b1110_1000, g, c);
        chk("e8_gnt", 32'(g), 32'b0001);
        wait_res();
        chk("e8_flags", 32'(bus.res_flags), 32'h0A);
        chk("e8_hits", 32'(bus.res_hits), 2);

        // All four held: 0,1,2,3,0 at 12-cycle spacing
        apply_reset();
        dut_gnt_ids.delete(); dut_gnt_cyc.delete(); dut_res_ids.delete();
        @(posedge clk); #1;
        for (int k = 0; k < NREQ; k++) bus.req_data[k*WIDTH +: WIDTH] = 8'($urandom);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_any_gnt(g, c);
        @(posedge clk); #1;
        bus.req = '0;
        wait_res();
        repeat (2) @(negedge clk);
        chk("rr_gnt_count", 32'(dut_gnt_ids.size()), 5);
        chk("rr_res_count", 32'(dut_res_ids.size()), 5);
        for (int i = 0; i < 5 && i < dut_gnt_ids.size(); i++) begin
            chk("rr_gnt_order", 32'(dut_gnt_ids[i]), 32'(i % NREQ));
            if (i > 0) chk("rr_gnt_gap", 32'(dut_gnt_cyc[i] - dut_gnt_cyc[i-1]), 12);
        end
        for (int i = 0; i < 5 && i < dut_res_ids.size(); i++)
            chk("rr_res_order", 32'(dut_res_ids[i]), 32'(i % NREQ));

        // req2 raised while req0 is shifting
        send_one(0, 8'($urandom), g, c);
        repeat (3) @(posedge clk);
        #1;
        bus.req_data[2*WIDTH +: WIDTH] = 8'($urandom);
        bus.req[2] = 1'b1;
        wait_any_gnt(g2, c2);
        chk("late_gnt", 32'(g2), 32'b0100);
        chk("late_gap", 32'(c2 - c), 12);
        @(posedge clk); #1;
        bus.req[2] = 1'b0;
        wait_res();

        // Reset pulsed at G+5 aborts the word
        repeat (2) @(posedge clk);
        send_one(0, 8'($urandom), g, c);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("abort_det_rst_n", 32'(det_rst_n), 0);
        chk("abort_det_x", 32'(det_x), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        chk("abort_no_res", 32'(seen), 0);
        @(posedge clk); #1;
        bus.req = 4'b0011;
        wait_any_gnt(g, c);
        chk("abort_ptr_reset", 32'(g), 32'b0001);
        @(posedge clk); #1;
        bus.req = '0;
        wait_res();

        // Randomized traffic with withdrawals
        rb = dut_res_cnt;
        granted_mask = '0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            bus.req = bus.req & ~granted_mask;
            granted_mask = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req[k] && $urandom_range(0, 9) == 0) begin
                    bus.req_data[k*WIDTH +: WIDTH] = 8'($urandom);
                    bus.req[k] = 1'b1;
                end else if (bus.req[k] && $urandom_range(0, 39) == 0) begin
                    bus.req[k] = 1'b0;
                end
            end
        end
        bus.req = '0;
        repeat (20) @(posedge clk);
        chk("random_progress", 32'(dut_res_cnt - rb > 20), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
